xalu_nibble_sequencer: RTL and testbench
========================================

# xalu_nibble_sequencer

Multi-nibble sequencer that drives one 4-bit ALU slice (function codes 0–7: ADD, AND, OR, XOR, PASSA, PASSB, SHR, SHL) to perform full-width operations one nibble per clock. It latches wide operands on a start request and presents one nibble pair per cycle to the slice. It routes the slice's carry/shift outputs back into its carry inputs for the next nibble, and assembles the result and status flags. It sits on the initiator side of the slice's cascade interface, replacing a hard-wired chain of slices.

## Interface
Parameters:
- NIBBLES, 4, number of nibbles per operation (legal 2..8); operand width W = 4*NIBBLES

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled when busy=0
- op  in  3  function code (0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL)
- a, b  in  W  operands
- cin  in  1  ADD carry-in / shift fill bit
- com  in  1  complement-output mode
- alu_a, alu_b  out  4  nibble to slice ports A, B
- alu_f  out  3  slice function code
- alu_ci_right, alu_ci_left  out  1  slice carry inputs
- alu_com  out  1  slice complement mode
- alu_d  in  4  slice data output
- alu_co_left, alu_co_right, alu_zero, alu_equ  in  1  slice status outputs
- result  out  W  assembled result
- cout  out  1  final carry/shift-out
- zero  out  1  all result nibbles zero
- equ  out  1  a == b over full width
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- start=1 in IDLE or DONE: latch a, b, op, cin, com; set zero_acc=1, equ_acc=1, chain=cin; load nibble index; → RUN.
- Order: SHR processes nibble NIBBLES-1 down to 0; all other ops process 0 up to NIBBLES-1.
- In RUN, the slice is driven combinationally from registers: alu_a/alu_b = current nibble, alu_f = op, alu_com = com.
- ADD/SHL: alu_ci_right = chain, alu_ci_left = 0.
- SHR: alu_ci_left = chain, alu_ci_right = 0.
- Other ops: both carry inputs 0.
- Each RUN edge:
  - write alu_d into result nibble slot;
  - zero_acc &= alu_zero; equ_acc &= alu_equ;
  - chain = alu_co_left (ADD/SHL), alu_co_right (SHR), 0 otherwise;
  - step index.
- After the last nibble → DONE for exactly one cycle, then → IDLE.
- cout = chain after the last nibble. zero and equ are the accumulated flags. zero reflects post-complement output.
- result, cout, zero and equ hold until the next accepted start. They are then cleared to 0 at acceptance.
- start while busy=1 is ignored; latched operands are unaffected.
- In IDLE/DONE, all alu_* outputs are driven 0.

## Timing
- Reset (async): state IDLE; result=0, cout=0, zero=0, equ=0, busy=0, done=0, all alu_* outputs 0.
- start sampled at edge T0 → busy=1 after T0; nibbles captured at edges T1..T(NIBBLES).
- done=1 and busy=0 for the single cycle after T(NIBBLES). Latency is NIBBLES+1 edges from start to the done-low edge.
- start held high during DONE: accepted at that edge. Back-to-back throughput is one operation per NIBBLES+1 cycles.
- Reset mid-RUN: abort immediately; no done pulse; outputs take reset values.

## Configuration
- XALU_SEQ_ROTATE_EN defined: the fill bit for SHL/SHR comes from the opposite operand end, not cin.
  - SHL: the initial chain is a[W-1].
  - SHR: the initial chain is a[0].
  - The result is a rotate; cout still reports the bit shifted out.
- Undefined: the fill bit is cin (logical shift with fill).

## Test plan
- ADD a=0x1234, b=0x0FFF, cin=0, com=0 → result=0x2233, cout=0, zero=0, done exactly 5 cycles after start edge.
- ADD a=0xFFFF, b=0x0001, cin=0 → result=0x0000, cout=1, zero=1; alu_ci_right observed 1 on nibbles 1–3.
- SHL a=0x8001, cin=1 → result=0x0003, cout=1. SHR a=0x8001, cin=0 → result=0x4000, cout=1, MSB nibble driven first. With XALU_SEQ_ROTATE_EN: SHL a=0x8001 → 0x0003; SHR a=0x8001 → 0xC000.
- XOR a=b=0xA5A5, com=0 → result=0x0000, zero=1, equ=1. Same with com=1 → result=0xFFFF, zero=0, equ=1.
- start pulsed during RUN with different operands → ignored, first result intact. start held through DONE → second operation accepted, done pulses twice, 5 cycles apart.
- rst_n low during nibble 2 of ADD → all outputs 0 asynchronously, no done. The next start completes normally.

Source files
------------

// File: rtl/xalu_nibble_sequencer.sv
// xalu_nibble_sequencer: runs a W-bit operation through one 4-bit ALU slice, one nibble per clock.
// Define XALU_SEQ_ROTATE_EN to fill SHL/SHR from the opposite operand end (rotate instead of shift).
module xalu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 com,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_f,
    output logic                 alu_ci_right,
    output logic                 alu_ci_left,
    output logic                 alu_com,
    input  logic [3:0]           alu_d,
    input  logic                 alu_co_left,
    input  logic                 alu_co_right,
    input  logic                 alu_zero,
    input  logic                 alu_equ,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 zero,
    output logic                 equ,
    output logic                 busy,
    output logic                 done
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SHR = 3'd6, OP_SHL = 3'd7;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]    op_q, op_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          com_q, com_d, chain_q, chain_d, zacc_q, zacc_d, eacc_q, eacc_d;
    logic          cout_q, cout_d, zero_q, zero_d, equ_q, equ_d;
    logic          run, shr, fwd, accept, last, fill, chain_nxt;

    assign run       = state_q == S_RUN;
    assign shr       = op_q == OP_SHR;
    assign fwd       = op_q == OP_ADD || op_q == OP_SHL;
    assign accept    = start && !run;
    assign last      = shr ? idx_q == '0 : idx_q == IW'(NIBBLES - 1);
    assign chain_nxt = fwd ? alu_co_left : shr ? alu_co_right : 1'b0;

`ifdef XALU_SEQ_ROTATE_EN
    assign fill = op == OP_SHL ? a[W-1] : op == OP_SHR ? a[0] : cin;
`else
    assign fill = cin;
`endif

    // Slice is driven straight from registers so each nibble settles within one cycle.
    assign alu_a        = run ? a_q[{idx_q, 2'b00} +: 4] : 4'h0;
    assign alu_b        = run ? b_q[{idx_q, 2'b00} +: 4] : 4'h0;
    assign alu_f        = run ? op_q : 3'd0;
    assign alu_com      = run && com_q;
    assign alu_ci_right = run && fwd && chain_q;
    assign alu_ci_left  = run && shr && chain_q;

    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign equ    = equ_q;
    assign busy   = run;
    assign done   = state_q == S_DONE;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        com_d    = com_q;
        idx_d    = idx_q;
        chain_d  = chain_q;
        zacc_d   = zacc_q;
        eacc_d   = eacc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        equ_d    = equ_q;
        if (accept) begin
            state_d  = S_RUN;
            a_d      = a;
            b_d      = b;
            op_d     = op;
            com_d    = com;
            idx_d    = op == OP_SHR ? IW'(NIBBLES - 1) : '0;
            chain_d  = fill;
            zacc_d   = 1'b1;
            eacc_d   = 1'b1;
            result_d = '0;
            cout_d   = 1'b0;
            zero_d   = 1'b0;
            equ_d    = 1'b0;
        end else if (run) begin
            result_d[{idx_q, 2'b00} +: 4] = alu_d;
            zacc_d  = zacc_q & alu_zero;
            eacc_d  = eacc_q & alu_equ;
            chain_d = chain_nxt;
            idx_d   = shr ? idx_q - 1'b1 : idx_q + 1'b1;
            if (last) begin
                state_d = S_DONE;
                cout_d  = chain_nxt;
                zero_d  = zacc_q & alu_zero;
                equ_d   = eacc_q & alu_equ;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            com_q    <= 1'b0;
            idx_q    <= '0;
            chain_q  <= 1'b0;
            zacc_q   <= 1'b0;
            eacc_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            equ_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            com_q    <= com_d;
            idx_q    <= idx_d;
            chain_q  <= chain_d;
            zacc_q   <= zacc_d;
            eacc_q   <= eacc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            equ_q    <= equ_d;
        end
    end
endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// tb_xalu_nibble_sequencer: randomized and directed checks against a whole-word reference model.
module tb_xalu_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, com = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic [3:0]   alu_a, alu_b, alu_d;
    logic [2:0]   alu_f;
    logic         alu_ci_right, alu_ci_left, alu_com, alu_co_left, alu_co_right, alu_zero, alu_equ;
    logic [W-1:0] result;
    logic         cout, zero, equ, busy, done;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    xalu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin), .com(com),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_ci_right(alu_ci_right),
        .alu_ci_left(alu_ci_left), .alu_com(alu_com), .alu_d(alu_d), .alu_co_left(alu_co_left),
        .alu_co_right(alu_co_right), .alu_zero(alu_zero), .alu_equ(alu_equ), .result(result),
        .cout(cout), .zero(zero), .equ(equ), .busy(busy), .done(done)
    );

    // 4-bit ALU slice attached to the sequencer
    logic [4:0] s_sum;
    logic [3:0] s_raw;
    always_comb begin
        s_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_ci_right};
        case (alu_f)
            3'd0:    s_raw = s_sum[3:0];
            3'd1:    s_raw = alu_a & alu_b;
            3'd2:    s_raw = alu_a | alu_b;
            3'd3:    s_raw = alu_a ^ alu_b;
            3'd4:    s_raw = alu_a;
            3'd5:    s_raw = alu_b;
            3'd6:    s_raw = {alu_ci_left, alu_a[3:1]};
            default: s_raw = {alu_a[2:0], alu_ci_right};
        endcase
        alu_d        = alu_com ? ~s_raw : s_raw;
        alu_co_left  = alu_f == 3'd0 ? s_sum[4] : alu_f == 3'd7 ? alu_a[3] : 1'b0;
        alu_co_right = alu_f == 3'd6 && alu_a[0];
        alu_zero     = alu_d == 4'd0;
        alu_equ      = alu_a == alu_b;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic fill_of(input logic [2:0] o, input logic [W-1:0] x, input logic c);
`ifdef XALU_SEQ_ROTATE_EN
        return o == 3'd7 ? x[W-1] : o == 3'd6 ? x[0] : c;
`else
        return c;
`endif
    endfunction

    // Whole-word result: {carry/shift-out, result}
    function automatic logic [W:0] full_of(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic m);
        logic [W:0] r;
        logic f;
        f = fill_of(o, x, c);
        case (o)
            3'd0:    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            3'd1:    r = {1'b0, x & y};
            3'd2:    r = {1'b0, x | y};
            3'd3:    r = {1'b0, x ^ y};
            3'd4:    r = {1'b0, x};
            3'd5:    r = {1'b0, y};
            3'd6:    r = {x[0], f, x[W-1:1]};
            default: r = {x[W-1], x[W-2:0], f};
        endcase
        r[W-1:0] = r[W-1:0] ^ {W{m}};
        return r;
    endfunction

    logic         m_busy, m_done, m_cin, m_com, m_cout, m_zero, m_equ;
    logic [2:0]   m_op;
    logic [W-1:0] m_a, m_b, m_res;
    int           m_k;
    logic [W:0]   m_full;
    assign m_full = full_of(m_op, m_a, m_b, m_cin, m_com);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_k <= 0; m_op <= 3'd0; m_a <= '0; m_b <= '0;
            m_cin <= 1'b0; m_com <= 1'b0; m_res <= '0; m_cout <= 1'b0; m_zero <= 1'b0; m_equ <= 1'b0;
        end else if (!m_busy && start) begin
            m_busy <= 1'b1; m_done <= 1'b0; m_k <= 0; m_op <= op; m_a <= a; m_b <= b;
            m_cin <= cin; m_com <= com; m_res <= '0; m_cout <= 1'b0; m_zero <= 1'b0; m_equ <= 1'b0;
        end else if (m_busy) begin
            if (m_k == N - 1) begin
                m_busy <= 1'b0; m_done <= 1'b1;
                m_res <= m_full[W-1:0]; m_cout <= m_full[W];
                m_zero <= m_full[W-1:0] == '0; m_equ <= m_a == m_b;
            end else begin
                m_k <= m_k + 1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    int          c_idx;
    logic        c_fill;
    logic [63:0] c_mask, c_carry, c_cir, c_cil;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (m_busy) begin
                c_idx   = m_op == 3'd6 ? N - 1 - m_k : m_k;
                c_fill  = fill_of(m_op, m_a, m_cin);
                c_mask  = (64'd1 << (4 * c_idx)) - 64'd1;
                c_carry = ((64'(m_a) & c_mask) + (64'(m_b) & c_mask) + 64'(m_cin)) >> (4 * c_idx);
                c_cir   = m_op == 3'd0 ? c_carry : m_op == 3'd7 ? (c_idx == 0 ? 64'(c_fill) : 64'(m_a[4*c_idx-1])) : 64'd0;
                c_cil   = m_op == 3'd6 ? (c_idx == N - 1 ? 64'(c_fill) : 64'(m_a[4*c_idx+4])) : 64'd0;
                chk("alu_a", alu_a, (m_a >> (4 * c_idx)) & 'hF);
                chk("alu_b", alu_b, (m_b >> (4 * c_idx)) & 'hF);
                chk("alu_f", alu_f, m_op);
                chk("alu_com", alu_com, m_com);
                chk("alu_ci_right", alu_ci_right, c_cir);
                chk("alu_ci_left", alu_ci_left, c_cil);
            end else begin
                chk("idle_alu", {alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left, alu_com}, 0);
                chk("result", result, m_res);
                chk("cout", cout, m_cout);
                chk("zero", zero, m_zero);
                chk("equ", equ, m_equ);
            end
        end
    end

    int          lat, t1, t2, ndone;
    logic [31:0] ci_hist;
    logic [3:0]  first_a;
    logic [W-1:0] r_a, r_b;

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic m, input logic pulse);
        @(negedge clk);
        op = o; a = x; b = y; cin = c; com = m; start = 1'b1;
        @(posedge clk);
        lat = 0;
        ci_hist = '0;
        while (lat < 4 * N) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) first_a = alu_a;
            ci_hist[lat] = alu_ci_right;
            if (pulse && lat == 2) begin
                start = 1'b1; a = ~x; b = W'($urandom); op = 3'($urandom);
            end
            if (done) break;
        end
        chk("done_lat", lat, N + 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", {cout, zero, equ, busy, done}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left, alu_com}, 0);
        rst_n = 1'b1;

        run_op(3'd0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        chk("add1_res", result, 16'h2233);
        chk("add1_flags", {cout, zero}, 2'b00);
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("add2_res", result, 16'h0000);
        chk("add2_flags", {cout, zero}, 2'b11);
        chk("add2_ci", ci_hist[4:1], 4'b1110);
        run_op(3'd7, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("shl_res", result, 16'h0003);
        chk("shl_cout", cout, 1'b1);
        run_op(3'd6, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef XALU_SEQ_ROTATE_EN
        chk("shr_res", result, 16'hC000);
`else
        chk("shr_res", result, 16'h4000);
`endif
        chk("shr_cout", cout, 1'b1);
        chk("shr_first", first_a, 4'h8);
        run_op(3'd3, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        chk("xor_res", result, 16'h0000);
        chk("xor_flags", {zero, equ}, 2'b11);
        run_op(3'd3, 16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 1'b0);
        chk("xorc_res", result, 16'hFFFF);
        chk("xorc_flags", {zero, equ}, 2'b01);
        run_op(3'd0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
        chk("ignore_res", result, 16'h2233);

        @(negedge clk);
        op = 3'd0; a = 16'h0101; b = 16'h0202; cin = 1'b0; com = 1'b0; start = 1'b1;
        t1 = 0; t2 = 0; ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (t1 == 0) t1 = i;
                else if (t2 == 0) t2 = i;
            end
            if (t1 != 0 && i == t1 + 1) start = 1'b0;
        end
        start = 1'b0;
        chk("b2b_first", t1, N + 1);
        chk("b2b_gap", t2 - t1, N + 1);
        chk("b2b_count", ndone, 2);
        chk("b2b_res", result, 16'h0303);

        @(negedge clk);
        op = 3'd0; a = 16'h1234; b = 16'h0FFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_result", result, 0);
        chk("arst_flags", {cout, zero, equ, busy, done}, 0);
        chk("arst_alu", {alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left, alu_com}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        run_op(3'd0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        chk("arst_next_res", result, 16'h2233);

        for (int i = 0; i < 60; i++) begin
            r_a = W'($urandom);
            r_b = $urandom_range(0, 3) == 0 ? r_a : W'($urandom);
            run_op(3'($urandom), r_a, r_b, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
